pipe_skid_stage: RTL

// - Elastic pipeline stage register between two 8051 core pipeline stages.
// - Complements the plain stage register: it is the flow-controlled side of the stage boundary.
// - Upstream and downstream sides use a valid/ready handshake, and a 2-entry skid register absorbs downstream back-pressure.
// - Sustains 1 beat/cycle with no combinational ready path from downstream to upstream.
// - i_flush discards contents on branch or interrupt redirect.

---
 rtl/pipe_skid_stage.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//
// Elastic pipeline stage between two 8051 core pipeline stages. A main
// register presents the head beat downstream; a skid register catches the one
// extra beat that upstream may push in the cycle downstream stalls. Every
// output is decoded from registers, so there is no combinational path from
// i_ready to o_ready and the stage still sustains one beat per cycle.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high on that side (in_fire = i_valid & o_ready, out_fire = o_valid & i_ready).
// The producer holds valid/data stable until the transfer; ready may change
// freely and carries no obligation when valid is low.
//
// Ports
//   i_clk    clock, all state changes on its rising edge
//   i_rst    synchronous active-high reset
//   i_flush  synchronous flush, drops held and incoming beats
//   i_valid  upstream beat valid
//   i_data   upstream payload (DATA_W bits)
//   o_ready  stage can accept a beat this cycle
//   o_valid  downstream beat valid
//   o_data   downstream payload (DATA_W bits), always the main register
//   i_ready  downstream accepts the beat this cycle
//   o_count  beats held: 0, 1 or 2 (also the observable FSM state)
// -----------------------------------------------------------------------------
module pipe_skid_stage #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic [1:0]        o_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire;

  // Registered-only output decode.
  assign o_valid  = (state_q != ST_EMPTY);
  assign o_ready  = (state_q != ST_FULL);
  assign o_data   = main_q;
  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  always_comb begin
    o_count = 2'd0;
    case (state_q)
      ST_BUSY: o_count = 2'd1;
      ST_FULL: o_count = 2'd2;
      default: o_count = 2'd0;
    endcase
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      // An input beat firing now is dropped; an output beat firing now has
      // already been taken downstream.
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_BUSY;
            main_d  = i_data;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_d = i_data;
          end else if (in_fire) begin
            // Downstream stalled: park the new beat behind the head.
            state_d = ST_FULL;
            skid_d  = i_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
          end
        end
        default: begin
          // Unused encoding: fall back to a clean empty stage.
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
